loop_mux_seq: RTL and testbench

Parametrised loop-counting channel sequencer.
- Selects one of NCH input words under control of a run enable and a channel select.
- Presents the selected word on a valid/ready output port.
- Counts idle iterations up to LOOP_MAX, then restarts its loop.
- Generalised successor of the fixed 2-input, 100-iteration selector FSM: parametrised width, channel count and loop bound, plus an output handshake and loop-done signalling.

---
 rtl/loop_mux_seq.sv | 119 +++++++++++
 tb/tb_loop_mux_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/loop_mux_seq.sv
// loop_mux_seq: loop-counting channel sequencer.
// Idles in RUN counting iterations up to LOOP_MAX. When enabled it captures
// one of NCH channel words and presents it on a valid/ready port. After a
// handshake or a completed loop it restarts through INIT/CLR.
module loop_mux_seq #(
  parameter int WIDTH    = 16,
  parameter int NCH      = 4,
  parameter int SELW     = 2,
  parameter int LOOP_MAX = 100,
  parameter int CNTW     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNTW-1:0]      iter,
  output logic                 done,
  output logic                 busy
);

  // LOOP_MAX must fit in CNTW bits. The counter stops at LOOP_MAX and never wraps.
  localparam logic [CNTW-1:0] LOOP_MAX_C = CNTW'(LOOP_MAX);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [WIDTH-1:0]              out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic [CNTW-1:0]               iter_q, iter_d;
  logic                          done_q, done_d;
  logic [NCH-1:0][WIDTH-1:0]     ch;
  logic [WIDTH-1:0]              sel_word;
  logic                          at_max;

  assign ch     = in_data;
  assign at_max = (iter_q == LOOP_MAX_C);

  // Channel mux; a select beyond the last channel yields a zero word
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NCH; k++)
      if (sel == SELW'(k)) sel_word = ch[k];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= INIT;
    else      state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: state_d = CLR;
      CLR:  state_d = RUN;
      RUN: begin
        if (at_max)  state_d = CLR;
        else if (en) state_d = HOLD;
      end
      HOLD: if (out_ready) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  // Datapath next values; done defaults low so it lasts exactly one cycle
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    iter_d      = iter_q;
    done_d      = 1'b0;
    unique case (state_q)
      CLR: iter_d = '0;
      RUN: begin
        if (at_max) begin
          done_d = 1'b1;
        end else if (en) begin
          out_data_d  = sel_word;
          out_valid_d = 1'b1;
        end else begin
          iter_d = iter_q + CNTW'(1);
        end
      end
      HOLD: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath registers; async reset discards any word in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      iter_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      iter_q      <= iter_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign iter      = iter_q;
  assign done      = done_q;
  assign busy      = (state_q != RUN);

endmodule

// File: tb/tb_loop_mux_seq.sv
// Bench for loop_mux_seq: a 4-channel and a 3-channel instance run in
// lockstep on shared controls and are compared against a behavioural model.
module tb_loop_mux_seq;

  localparam int W  = 16;
  localparam int LM = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data4 = '0;
  logic [47:0] in_data3;

  logic [W-1:0] od4, od3;
  logic         ov4, ov3, dn4, dn3, bz4, bz3;
  logic [6:0]   it4, it3;

  assign in_data3 = in_data4[47:0];

  loop_mux_seq #(.WIDTH(W), .NCH(4), .SELW(2), .LOOP_MAX(LM), .CNTW(7)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .in_data(in_data4),
    .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
    .iter(it4), .done(dn4), .busy(bz4));

  loop_mux_seq #(.WIDTH(W), .NCH(3), .SELW(2), .LOOP_MAX(LM), .CNTW(7)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .in_data(in_data3),
    .out_data(od3), .out_valid(ov3), .out_ready(out_ready),
    .iter(it3), .done(dn3), .busy(bz3));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  // Behavioural model: restart = edges left before the sequencer is idle-counting
  // again, pend = a word is on offer, cnt = idle iterations this loop.
  int          restart;
  bit          pend;
  int          cnt;
  bit          mdone;
  logic [15:0] mword4, mword3;

  task automatic model_reset();
    restart = 2; pend = 0; cnt = 0; mdone = 0; mword4 = '0; mword3 = '0;
  endtask

  task automatic model_edge(input bit e, input logic [1:0] s, input bit rdy,
                            input logic [63:0] d);
    bit nd = 0;
    if (pend) begin
      if (rdy) begin pend = 0; restart = 2; end
    end else if (restart == 2) begin
      restart = 1;
    end else if (restart == 1) begin
      restart = 0; cnt = 0;
    end else if (cnt == LM) begin
      nd = 1; restart = 1;
    end else if (e) begin
      pend   = 1;
      mword4 = d[int'(s)*16 +: 16];
      mword3 = (int'(s) < 3) ? d[int'(s)*16 +: 16] : 16'h0000;
    end else begin
      cnt++;
    end
    mdone = nd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit bsy;
    bsy = pend || (restart != 0);
    chk({tag, " data4"},  {16'b0, od4}, {16'b0, mword4});
    chk({tag, " data3"},  {16'b0, od3}, {16'b0, mword3});
    chk({tag, " valid4"}, {31'b0, ov4}, {31'b0, pend});
    chk({tag, " valid3"}, {31'b0, ov3}, {31'b0, pend});
    chk({tag, " iter4"},  {25'b0, it4}, 32'(cnt));
    chk({tag, " iter3"},  {25'b0, it3}, 32'(cnt));
    chk({tag, " done4"},  {31'b0, dn4}, {31'b0, mdone});
    chk({tag, " done3"},  {31'b0, dn3}, {31'b0, mdone});
    chk({tag, " busy4"},  {31'b0, bz4}, {31'b0, bsy});
    chk({tag, " busy3"},  {31'b0, bz3}, {31'b0, bsy});
  endtask

  // One clock edge: model consumes the inputs the DUT sampled, then compare
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_edge(en, sel, out_ready, in_data4);
    #1;
    if (mdone) done_seen++;
    check_all(tag);
  endtask

  // Idle until the sequencer is counting and able to accept en
  task automatic wait_run(input string tag);
    int n = 0;
    en = 0;
    while (!(restart == 0 && !pend && cnt < LM) && n < 300) begin
      step(tag); n++;
    end
    chk({tag, " wait_run timeout"}, 32'(n < 300), 32'd1);
  endtask

  initial begin
    model_reset();
    // Reset asserted asynchronously, held two cycles
    #2 rst = 0;
    #1 check_all("reset");
    @(posedge clk); #1 check_all("reset hold1");
    @(posedge clk); #1 check_all("reset hold2");
    rst = 1;

    // 1. Idle loop: counts to LOOP_MAX, done pulses once, restarts via CLR
    done_seen = 0;
    for (int i = 0; i < 106; i++) step("idle");
    chk("idle done count", 32'(done_seen), 32'd1);
    chk("idle iter restart", {25'b0, it4}, 32'd2);

    // 2. Channel select, immediate accept
    in_data4 = 64'h4444_BEEF_2222_1111;
    wait_run("sel2 wait");
    en = 1; sel = 2; out_ready = 1;
    step("sel2 issue");
    chk("sel2 word", {16'b0, od4}, 32'h0000_BEEF);
    en = 0;
    step("sel2 accept");
    chk("sel2 valid low", {31'b0, ov4}, 32'd0);
    out_ready = 0;
    step("sel2 clr");
    step("sel2 run");
    chk("sel2 iter zero", {25'b0, it4}, 32'd0);

    // 3. Backpressure: word captured at issue is held while input changes
    in_data4 = 64'h0000_0000_1234_0000;
    wait_run("bp wait");
    en = 1; sel = 1; out_ready = 0;
    step("bp issue");
    in_data4 = 64'h0000_0000_5678_0000; sel = 0; en = 0;
    for (int i = 0; i < 5; i++) begin
      step("bp hold");
      chk("bp held word", {15'b0, ov4, od4}, 32'h0001_1234);
    end
    out_ready = 1;
    step("bp accept");
    chk("bp accepted", {31'b0, ov4}, 32'd0);
    out_ready = 0;

    // 4. Out-of-range select on the 3-channel instance
    in_data4 = 64'hABCD_0003_0002_0001;
    wait_run("oor wait");
    en = 1; sel = 3;
    step("oor issue");
    chk("oor nch3 zero", {15'b0, ov3, od3}, 32'h0001_0000);
    chk("oor nch4 ch3", {15'b0, ov4, od4}, 32'h0001_ABCD);
    en = 0; out_ready = 1;
    step("oor accept");
    out_ready = 0;

    // 5. Mid-loop enable at iter 40: no done pulse across the whole loop
    wait_run("mid wait");
    done_seen = 0;
    for (int i = 0; i < 120 && cnt != 40; i++) step("mid idle");
    chk("mid iter40", {25'b0, it4}, 32'd40);
    in_data4 = 64'h0000_0000_0000_C0DE;
    en = 1; sel = 0;
    step("mid issue");
    chk("mid word", {16'b0, od4}, 32'h0000_C0DE);
    en = 0; out_ready = 1;
    step("mid accept");
    out_ready = 0;
    step("mid init"); step("mid clr");
    chk("mid iter cleared", {25'b0, it4}, 32'd0);
    chk("mid no done", 32'(done_seen), 32'd0);

    // 6. Reset in HOLD: valid and word drop immediately, mid-cycle
    in_data4 = 64'h0000_7777_0000_0000;
    wait_run("rsth wait");
    en = 1; sel = 2; out_ready = 0;
    step("rsth issue");
    en = 0;
    step("rsth held");
    #2 rst = 0;
    #1 model_reset();
    check_all("rsth async");
    chk("rsth valid", {31'b0, ov4}, 32'd0);
    step("rsth hold");
    rst = 1;
    step("rsth init");
    step("rsth clr");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 39) == 0);
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) == 0);
      in_data4  = {$urandom, $urandom};
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
